accel_wb_master: RTL
====================

ACCEL_WB_MASTER -- requirements
Module: accel_wb_master

Interface
REQ-001 Parameter ADDR_OFFSET, default 32'h3000_0000, byte base address of the accelerator window.
REQ-002 Parameter ACK_TIMEOUT, default 255, maximum cycles to wait for ack per beat.
REQ-003 Port: wb_clk_i, input, 1, the single clock.
REQ-004 Port: wb_rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 Command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write burst, 0=read burst); cmd_word in 16 (start word index); cmd_len in 16 (beat count).
REQ-006 Write-data ports: wr_valid in 1; wr_ready out 1; wr_data in 32.
REQ-007 Read-data ports: rd_valid out 1; rd_ready in 1; rd_data out 32.
REQ-008 Status ports: done out 1 (one-cycle pulse); err out 1 (sticky).
REQ-009 Wishbone master ports: wbm_cyc_o out 1; wbm_stb_o out 1; wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o out 32; wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i in 1.

Function
REQ-010 States IDLE, FETCH, BUS, GAP, RESP, DONE, ERR; encoding internal.
REQ-011 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches we, word, len, clears beat counter; len=0 -> DONE directly, no bus activity.
REQ-012 Accepted write command -> FETCH; read command -> BUS.
REQ-013 FETCH: wr_ready=1; wr_valid&wr_ready captures wr_data into data register, -> BUS next cycle.
REQ-014 BUS: cyc=stb=1, sel=4'hF, we=latched we, adr=ADDR_OFFSET+4*(word+beat), dat_o=data register; all held stable until ack.
REQ-015 Address arithmetic 32-bit, wraps modulo 2^32; word+beat computed 17-bit, no saturation.
REQ-016 BUS with wbm_ack_i=1: cyc and stb deasserted on following edge; read captures wbm_dat_i same edge; -> GAP.
REQ-017 GAP: exactly one cycle cyc=stb=0; then read -> RESP, write -> FETCH or DONE.
REQ-018 RESP: rd_valid=1, rd_data stable; rd_valid&rd_ready -> BUS for next beat or DONE after last.
REQ-019 Beat counter increments once per acked beat; last beat when beat+1==len.
REQ-020 BUS timeout: counter resets on BUS entry; ACK_TIMEOUT cycles without ack -> ERR, cyc/stb dropped next edge.
REQ-021 ERR: err=1 sticky; remaining beats abandoned; no further bus cycles; -> DONE.
REQ-022 DONE: done=1 one cycle, -> IDLE; err stays until next accepted command, which clears it.
REQ-023 cmd_ready=0 outside IDLE; cmd_valid ignored when busy.
REQ-024 wr_ready=1 only in FETCH; rd_valid=1 only in RESP.
REQ-025 Ack arriving while stb=0 ignored.
REQ-026 Ack and timeout expiry same cycle: ack wins, beat completes.
REQ-027 Exactly one beat outstanding; minimum 3 cycles per beat (BUS, GAP, next state).

Reset
REQ-028 wb_rst_i asynchronous, active-high; asserted at any time, including mid-beat, forces IDLE immediately.
REQ-029 Reset values: cyc/stb/we=0, sel=0, adr=0, dat_o=0, rd_data=0, rd_valid=0, wr_ready=0, cmd_ready=0 during reset then 1 in IDLE, done=0, err=0, counters 0.

Structure
REQ-030 Shared package holds state typedef, ACK_TIMEOUT default, bus width constant 32, byte-per-word constant 4.
REQ-031 One sub-module wb_ack_timer (loadable down-counter, expiry flag) is natural; remainder flat.

Verification
REQ-032 Write len=3, word=1, data 11/22/33, slave acks after 1 cycle -> writes at 3000_0004/08/0C with those data, sel=F, one idle cycle between beats, done once.
REQ-033 Read len=2, word=6, slave returns AAAA_0001, AAAA_0002 -> rd_data sequence matches; rd_ready low 5 cycles holds RESP with no new bus cycle.
REQ-034 Slave never acks, ACK_TIMEOUT=8 -> cyc drops after 8 BUS cycles; err=1, done pulse; next command clears err.
REQ-035 len=0 -> done pulse 1 cycle after accept; cyc never asserted.
REQ-036 Reset asserted mid-BUS of second write beat -> cyc/stb 0 asynchronously; after release, new command runs cleanly from beat 0.
REQ-037 word=16'hFFFF, len=2, ADDR_OFFSET=FFFF_FFF0 -> addresses wrap modulo 2^32 without error.

Source files
------------

// File: rtl/accel_wb_master_pkg.sv
// accel_wb_master_pkg
// Shared definitions for the accelerator Wishbone master: FSM state type,
// bus geometry constants, the default ack timeout, and the beat address helper.
package accel_wb_master_pkg;

    localparam int BUS_W           = 32;
    localparam int BYTES_PER_WORD  = 4;
    localparam int ACK_TIMEOUT_DEF = 255;
    localparam int TMR_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BUS,
        ST_GAP,
        ST_RESP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Byte address of a beat. The word index is summed in 17 bits so a start
    // word near 16'hFFFF keeps counting upward; the final add wraps mod 2^32.
    function automatic logic [BUS_W-1:0] beat_addr(input logic [BUS_W-1:0] base,
                                                   input logic [15:0]      word,
                                                   input logic [15:0]      beat);
        logic [16:0] idx;
        idx = {1'b0, word} + {1'b0, beat};
        return base + (BUS_W'(idx) * BUS_W'(BYTES_PER_WORD));
    endfunction

endpackage

// File: rtl/accel_wb_master_if.sv
// accel_wb_master_if
// Wishbone bus between the accelerator master and its slave.
//   master modport: drives cyc/stb/we/sel/adr/dat_o, receives dat_i/ack
//   slave  modport: the mirror image
interface accel_wb_master_if;
    import accel_wb_master_pkg::*;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [BUS_W-1:0] wbm_adr_o;
    logic [BUS_W-1:0] wbm_dat_o;
    logic [BUS_W-1:0] wbm_dat_i;
    logic             wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/accel_wb_master_wb_ack_timer.sv
// wb_ack_timer
// Loadable down-counter guarding a single bus beat.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   load, load_val     : reload the counter (takes priority over en)
//   en                 : count down by one, stopping at zero
//   expired            : counter has reached zero
module wb_ack_timer #(
    parameter int W = 16
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/accel_wb_master.sv
// accel_wb_master
// Turns word-indexed burst commands into single-beat Wishbone classic cycles.
//   wb_clk_i, wb_rst_i             : clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_we,
//   cmd_word, cmd_len              : burst command (direction, start word, beats)
//   wr_valid/ready, wr_data        : write data, one word per write beat
//   rd_valid/ready, rd_data        : read data, one word per read beat
//   done                           : one-cycle pulse at burst end
//   err                            : sticky ack timeout, cleared by next command
//   wbm                            : Wishbone master bus
module accel_wb_master
    import accel_wb_master_pkg::*;
#(
    parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [15:0]       cmd_word,
    input  logic [15:0]       cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BUS_W-1:0]  wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [BUS_W-1:0]  rd_data,
    output logic              done,
    output logic              err,
    accel_wb_master_if.master wbm
);

    // The timer counts BUS cycles; loading one short of ACK_TIMEOUT makes it
    // read zero during the ACK_TIMEOUT-th BUS cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic             we_q;
    logic [15:0]      word_q;
    logic [15:0]      len_q;
    logic [15:0]      beat_q;
    logic             bus_act;
    logic [BUS_W-1:0] adr_q;
    logic [BUS_W-1:0] dat_q;
    logic             tmr_expired;

    // Held in reload outside BUS, so every BUS entry starts a fresh count.
    wb_ack_timer #(.W(TMR_W)) u_ack_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (state != ST_BUS),
        .load_val (TMR_LOAD),
        .en       (state == ST_BUS),
        .expired  (tmr_expired)
    );

    // cyc and stb always move together; we/sel only mean something inside a cycle.
    assign wbm.wbm_cyc_o = bus_act;
    assign wbm.wbm_stb_o = bus_act;
    assign wbm.wbm_we_o  = bus_act & we_q;
    assign wbm.wbm_sel_o = {4{bus_act}};
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            word_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            bus_act   <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        we_q      <= cmd_we;
                        word_q    <= cmd_word;
                        len_q     <= cmd_len;
                        beat_q    <= '0;
                        err       <= 1'b0;
                        if (cmd_len == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (cmd_we) begin
                            wr_ready <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            bus_act <= 1'b1;
                            adr_q   <= beat_addr(ADDR_OFFSET, cmd_word, 16'd0);
                            state   <= ST_BUS;
                        end
                    end
                end

                ST_FETCH: begin
                    if (wr_valid && wr_ready) begin
                        wr_ready <= 1'b0;
                        dat_q    <= wr_data;
                        bus_act  <= 1'b1;
                        adr_q    <= beat_addr(ADDR_OFFSET, word_q, beat_q);
                        state    <= ST_BUS;
                    end
                end

                // Ack is checked before expiry so a same-cycle ack still completes.
                ST_BUS: begin
                    if (wbm.wbm_ack_i) begin
                        bus_act <= 1'b0;
                        beat_q  <= beat_q + 16'd1;
                        if (!we_q) begin
                            rd_data <= wbm.wbm_dat_i;
                        end
                        state <= ST_GAP;
                    end else if (tmr_expired) begin
                        bus_act <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_ERR;
                    end
                end

                // beat_q has already been advanced, so beat_q == len_q marks the last beat.
                ST_GAP: begin
                    if (!we_q) begin
                        rd_valid <= 1'b1;
                        state    <= ST_RESP;
                    end else if (beat_q == len_q) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wr_ready <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end

                ST_RESP: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (beat_q == len_q) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            bus_act <= 1'b1;
                            adr_q   <= beat_addr(ADDR_OFFSET, word_q, beat_q);
                            state   <= ST_BUS;
                        end
                    end
                end

                ST_ERR: begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
